// File: rtl/chess_cursor_ctrl_pkg.sv
// Shared types and constants for the chess cursor, move-validation and display blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: coordinate type, direction enum, board default size, button indices.
package chess_pkg;

  // Default board edge length (files and ranks).
  localparam int BOARD_SIZE_DEFAULT = 8;

  // Coordinate width used by the default 8x8 board.
  localparam int COORD_W_DEFAULT = 3;

  typedef logic [COORD_W_DEFAULT-1:0] coord_t;

  // Direction buttons. The encoding doubles as the index into the per-button
  // press vector in the cursor controller.
  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  // Four direction buttons plus select; select sits after the directions.
  localparam int NUM_BTN = 5;
  localparam int BTN_SEL = 4;

endpackage

// File: rtl/chess_cursor_ctrl_if.sv
// Button inputs and cursor/select outputs of the board cursor controller.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are free-running levels or one-cycle strobes.
//
// Signals: btn_up/down/left/right/select (raw, active-high), cursor_x/y,
//          move_pulse, select_pulse, sel_x/y.
// Modports: master = board side (drives buttons, observes cursor),
//           slave  = cursor controller.
interface chess_cursor_ctrl_if #(
  parameter int COORD_W = 3
);
  logic               btn_up;
  logic               btn_down;
  logic               btn_right;
  logic               btn_left;
  logic               btn_select;
  logic [COORD_W-1:0] cursor_x;
  logic [COORD_W-1:0] cursor_y;
  logic               move_pulse;
  logic               select_pulse;
  logic [COORD_W-1:0] sel_x;
  logic [COORD_W-1:0] sel_y;

  modport master (
    output btn_up, btn_down, btn_right, btn_left, btn_select,
    input  cursor_x, cursor_y, move_pulse, select_pulse, sel_x, sel_y
  );

  modport slave (
    input  btn_up, btn_down, btn_right, btn_left, btn_select,
    output cursor_x, cursor_y, move_pulse, select_pulse, sel_x, sel_y
  );
endinterface

// File: rtl/chess_cursor_ctrl_button_debounce.sv
// Button conditioner: 2-FF synchroniser, debounce counter, rising-edge press pulse.
// Latency: press_pulse high DEBOUNCE_CYCLES+2 cycles after the first sampling edge of a steady press.
// Backpressure: none; a press is a one-cycle strobe and is never held or queued.
//
// Ports: clk, reset_n (async active-low), btn_raw (asynchronous, active-high),
//        press_pulse (one-cycle strobe on an accepted press).
// Optional: CHESS_CURSOR_AUTOREPEAT_EN adds HOLD_CYCLES / REPEAT_CYCLES / REPEAT_EN
//           and emits repeat strobes while the debounced level stays high.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
`ifdef CHESS_CURSOR_AUTOREPEAT_EN
  ,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000,
  parameter bit REPEAT_EN       = 1'b1
`endif
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic press_pulse
);

  // Counter only ever holds 0..DEBOUNCE_CYCLES-1; keep at least one bit.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic             stable_q, stable_d;
  logic             stable_prev_q, stable_prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise;

  always_comb begin
    sync_d        = {sync_q[0], btn_raw};
    stable_d      = stable_q;
    stable_prev_d = stable_q;
    cnt_d         = '0;
    // Count only while the synchronised level disagrees with the accepted
    // level; any agreement (a glitch ending) restarts the count from zero.
    if (sync_q[1] != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = ~stable_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Release edges are deliberately ignored.
  assign rise = stable_q & ~stable_prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q        <= '0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      sync_q        <= sync_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_prev_d;
      cnt_q         <= cnt_d;
    end
  end

`ifdef CHESS_CURSOR_AUTOREPEAT_EN
  // rpt_cnt_q counts cycles since the last press or repeat strobe; rpt_phase_q
  // selects the long initial hold (0) or the shorter repeat interval (1).
  logic [31:0] rpt_cnt_q, rpt_cnt_d;
  logic        rpt_phase_q, rpt_phase_d;
  logic        rpt_fire;
  logic [31:0] rpt_limit;

  always_comb begin
    rpt_cnt_d   = rpt_cnt_q;
    rpt_phase_d = rpt_phase_q;
    rpt_fire    = 1'b0;
    rpt_limit   = rpt_phase_q ? 32'(REPEAT_CYCLES) : 32'(HOLD_CYCLES);
    if (!REPEAT_EN || !stable_q) begin
      // Released (or repeat disabled): drop any pending repeat at once.
      rpt_cnt_d   = '0;
      rpt_phase_d = 1'b0;
    end else if (rise) begin
      rpt_cnt_d   = 32'd1;
      rpt_phase_d = 1'b0;
    end else if (rpt_cnt_q == rpt_limit) begin
      rpt_fire    = 1'b1;
      rpt_cnt_d   = 32'd1;
      rpt_phase_d = 1'b1;
    end else begin
      rpt_cnt_d   = rpt_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rpt_cnt_q   <= '0;
      rpt_phase_q <= 1'b0;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_phase_q <= rpt_phase_d;
    end
  end

  assign press_pulse = rise | rpt_fire;
`else
  assign press_pulse = rise;
`endif

endmodule

// File: rtl/chess_cursor_ctrl.sv
// Board-selection cursor: debounced direction/select buttons move an (x,y) cursor and latch it on select.
// Latency: cursor/select outputs update DEBOUNCE_CYCLES+3 cycles after the first sampling edge of a steady press.
// Backpressure: none; move_pulse/select_pulse are one-cycle strobes, downstream must take them when they appear.
//
// Ports: clk, reset_n (async active-low), bus (chess_cursor_ctrl_if.slave):
//        btn_* raw buttons in; cursor_x/y, move_pulse, select_pulse, sel_x/y out.
// Optional: CHESS_CURSOR_AUTOREPEAT_EN adds HOLD_CYCLES / REPEAT_CYCLES and
//           auto-repeat on the four direction buttons (never on select).
// Parameter constraints: BOARD_W,BOARD_H >= 2; 2**COORD_W >= max(BOARD_W,BOARD_H);
//                        DEBOUNCE_CYCLES >= 1.
module chess_cursor_ctrl
  import chess_pkg::*;
#(
  parameter int BOARD_W         = BOARD_SIZE_DEFAULT,
  parameter int BOARD_H         = BOARD_SIZE_DEFAULT,
  parameter int COORD_W         = 3,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int WRAP            = 1
`ifdef CHESS_CURSOR_AUTOREPEAT_EN
  ,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000
`endif
) (
  input  logic                clk,
  input  logic                reset_n,
  chess_cursor_ctrl_if.slave  bus
);

  // One extra bit so +1 at the top edge never relies on natural overflow;
  // edges are detected by explicit compare, so any board size works.
  typedef logic [COORD_W:0] ext_t;
  localparam ext_t X_MAX = ext_t'(BOARD_W - 1);
  localparam ext_t Y_MAX = ext_t'(BOARD_H - 1);

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] press;

  assign btn_raw[int'(DIR_UP)]    = bus.btn_up;
  assign btn_raw[int'(DIR_DOWN)]  = bus.btn_down;
  assign btn_raw[int'(DIR_LEFT)]  = bus.btn_left;
  assign btn_raw[int'(DIR_RIGHT)] = bus.btn_right;
  assign btn_raw[BTN_SEL]         = bus.btn_select;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef CHESS_CURSOR_AUTOREPEAT_EN
      ,
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES),
      .REPEAT_EN       (i != BTN_SEL)
`endif
    ) u_debounce (
      .clk         (clk),
      .reset_n     (reset_n),
      .btn_raw     (btn_raw[i]),
      .press_pulse (press[i])
    );
  end

  logic [COORD_W-1:0] cur_x_q, cur_x_d;
  logic [COORD_W-1:0] cur_y_q, cur_y_d;
  logic [COORD_W-1:0] sel_x_q, sel_x_d;
  logic [COORD_W-1:0] sel_y_q, sel_y_d;
  logic               move_pulse_q, move_pulse_d;
  logic               select_pulse_q, select_pulse_d;

  logic p_up, p_down, p_left, p_right, p_sel;
  ext_t x_ext, y_ext, x_nxt, y_nxt;

  assign p_up    = press[int'(DIR_UP)];
  assign p_down  = press[int'(DIR_DOWN)];
  assign p_left  = press[int'(DIR_LEFT)];
  assign p_right = press[int'(DIR_RIGHT)];
  assign p_sel   = press[BTN_SEL];

  assign x_ext = {1'b0, cur_x_q};
  assign y_ext = {1'b0, cur_y_q};

  always_comb begin
    x_nxt = x_ext;
    y_nxt = y_ext;

    // Opposing presses in the same cycle cancel on that axis only.
    if (p_right && !p_left) begin
      if (x_ext == X_MAX) x_nxt = (WRAP != 0) ? ext_t'(0) : x_ext;
      else                x_nxt = x_ext + ext_t'(1);
    end else if (p_left && !p_right) begin
      if (x_ext == ext_t'(0)) x_nxt = (WRAP != 0) ? X_MAX : x_ext;
      else                    x_nxt = x_ext - ext_t'(1);
    end

    if (p_up && !p_down) begin
      if (y_ext == Y_MAX) y_nxt = (WRAP != 0) ? ext_t'(0) : y_ext;
      else                y_nxt = y_ext + ext_t'(1);
    end else if (p_down && !p_up) begin
      if (y_ext == ext_t'(0)) y_nxt = (WRAP != 0) ? Y_MAX : y_ext;
      else                    y_nxt = y_ext - ext_t'(1);
    end

    cur_x_d = x_nxt[COORD_W-1:0];
    cur_y_d = y_nxt[COORD_W-1:0];

    // Strobe only on a real change: saturated or cancelled moves are silent.
    move_pulse_d = (cur_x_d != cur_x_q) || (cur_y_d != cur_y_q);

    // Select captures the cursor as it was before any simultaneous move.
    select_pulse_d = p_sel;
    sel_x_d        = p_sel ? cur_x_q : sel_x_q;
    sel_y_d        = p_sel ? cur_y_q : sel_y_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_x_q        <= '0;
      cur_y_q        <= '0;
      sel_x_q        <= '0;
      sel_y_q        <= '0;
      move_pulse_q   <= 1'b0;
      select_pulse_q <= 1'b0;
    end else begin
      cur_x_q        <= cur_x_d;
      cur_y_q        <= cur_y_d;
      sel_x_q        <= sel_x_d;
      sel_y_q        <= sel_y_d;
      move_pulse_q   <= move_pulse_d;
      select_pulse_q <= select_pulse_d;
    end
  end

  assign bus.cursor_x     = cur_x_q;
  assign bus.cursor_y     = cur_y_q;
  assign bus.sel_x        = sel_x_q;
  assign bus.sel_y        = sel_y_q;
  assign bus.move_pulse   = move_pulse_q;
  assign bus.select_pulse = select_pulse_q;

endmodule

// File: tb/tb_chess_cursor_ctrl.sv
// Bench for chess_cursor_ctrl: three boards (8x8 wrap, 5x5 wrap, 5x5 saturate)
// driven by the same buttons, each with a reference model and an expected-strobe queue.
module tb_chess_cursor_ctrl;
  import chess_pkg::*;

  localparam int DEB = 4;
  localparam int LAT = DEB + 3;
`ifdef CHESS_CURSOR_AUTOREPEAT_EN
  localparam int HOLD = 10;
  localparam int REP  = 3;
`endif

  // Button mask bits: [0]=up [1]=down [2]=left [3]=right [4]=select
  localparam logic [4:0] M_UP    = 5'b00001;
  localparam logic [4:0] M_RIGHT = 5'b01000;
  localparam logic [4:0] M_LEFT  = 5'b00100;
  localparam logic [4:0] M_UDR   = 5'b01011;
  localparam logic [4:0] M_SELR  = 5'b11000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  chess_cursor_ctrl_if #(.COORD_W(3)) bus0 ();
  chess_cursor_ctrl_if #(.COORD_W(3)) bus1 ();
  chess_cursor_ctrl_if #(.COORD_W(3)) bus2 ();

  chess_cursor_ctrl #(.BOARD_W(8), .BOARD_H(8), .COORD_W(3), .DEBOUNCE_CYCLES(DEB), .WRAP(1)
`ifdef CHESS_CURSOR_AUTOREPEAT_EN
    , .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
`endif
  ) u_dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));

  chess_cursor_ctrl #(.BOARD_W(5), .BOARD_H(5), .COORD_W(3), .DEBOUNCE_CYCLES(DEB), .WRAP(1)
`ifdef CHESS_CURSOR_AUTOREPEAT_EN
    , .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
`endif
  ) u_dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));

  chess_cursor_ctrl #(.BOARD_W(5), .BOARD_H(5), .COORD_W(3), .DEBOUNCE_CYCLES(DEB), .WRAP(0)
`ifdef CHESS_CURSOR_AUTOREPEAT_EN
    , .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
`endif
  ) u_dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2));

  typedef struct {
    int cyc;
    int x;
    int y;
    int sx;
    int sy;
    bit mv;
    bit sp;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  coord_t mx[3];
  coord_t my[3];
  coord_t msx[3];
  coord_t msy[3];
  int bw[3]    = '{8, 5, 5};
  int bh[3]    = '{8, 5, 5};
  bit bwrap[3] = '{1'b1, 1'b1, 1'b0};

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void qpush(input int k, input exp_t e);
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic int qsize(input int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t qfront(input int k);
    case (k)
      0: return q0[0];
      1: return q1[0];
      default: return q2[0];
    endcase
  endfunction

  function automatic exp_t qpop(input int k);
    case (k)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic int step(input int v, input int d, input int n, input bit wrap);
    if (d > 0) return (v == n - 1) ? (wrap ? 0 : v) : v + 1;
    if (d < 0) return (v == 0) ? (wrap ? n - 1 : 0) : v - 1;
    return v;
  endfunction

  // Apply one set of simultaneous press pulses to every board's model and
  // queue the strobe it must produce at output cycle t (if any).
  function automatic void model_event(input logic [4:0] m, input int t);
    int dx, dy, nx, ny;
    exp_t e;
    dx = int'(m[3]) - int'(m[2]);
    dy = int'(m[0]) - int'(m[1]);
    for (int k = 0; k < 3; k++) begin
      nx = step(int'(mx[k]), dx, bw[k], bwrap[k]);
      ny = step(int'(my[k]), dy, bh[k], bwrap[k]);
      e.cyc = t;
      e.x   = nx;
      e.y   = ny;
      e.mv  = (nx != int'(mx[k])) || (ny != int'(my[k]));
      e.sp  = m[4];
      e.sx  = m[4] ? int'(mx[k]) : int'(msx[k]);
      e.sy  = m[4] ? int'(my[k]) : int'(msy[k]);
      if (e.mv || e.sp) qpush(k, e);
      msx[k] = coord_t'(e.sx);
      msy[k] = coord_t'(e.sy);
      mx[k]  = coord_t'(nx);
      my[k]  = coord_t'(ny);
    end
  endfunction

  function automatic void model_reset();
    q0.delete();
    q1.delete();
    q2.delete();
    for (int k = 0; k < 3; k++) begin
      mx[k] = '0; my[k] = '0; msx[k] = '0; msy[k] = '0;
    end
  endfunction

  // Queue the first press and, with auto-repeat, every repeat that fits in
  // a hold of h sampled cycles (debounced level is high for h cycles).
  function automatic void model_press(input logic [4:0] m, input int n, input int h);
    model_event(m, n + LAT);
`ifdef CHESS_CURSOR_AUTOREPEAT_EN
    if (m[3:0] != 4'b0) begin
      for (int t = HOLD; t <= h - 1; t += REP) model_event({1'b0, m[3:0]}, n + LAT + t);
    end
`else
    if (h < 0) model_event(m, n);
`endif
  endfunction

  task automatic drive(input logic [4:0] m);
    bus0.btn_up = m[0]; bus0.btn_down = m[1]; bus0.btn_left = m[2];
    bus0.btn_right = m[3]; bus0.btn_select = m[4];
    bus1.btn_up = m[0]; bus1.btn_down = m[1]; bus1.btn_left = m[2];
    bus1.btn_right = m[3]; bus1.btn_select = m[4];
    bus2.btn_up = m[0]; bus2.btn_down = m[1]; bus2.btn_left = m[2];
    bus2.btn_right = m[3]; bus2.btn_select = m[4];
  endtask

  task automatic press(input logic [4:0] m, input int h);
    int n;
    @(negedge clk);
    drive(m);
    n = cyc;
    model_press(m, n, h);
    repeat (h) @(negedge clk);
    drive(5'b0);
    repeat (10) @(negedge clk);
  endtask

  task automatic mon(input int k, input logic mv, input logic sp,
                     input logic [2:0] cx, input logic [2:0] cy,
                     input logic [2:0] sx, input logic [2:0] sy);
    exp_t e;
    if (mv || sp) begin
      if (qsize(k) == 0) begin
        check($sformatf("d%0d_unexpected_strobe", k), int'({mv, sp}), 0);
      end else begin
        e = qpop(k);
        check($sformatf("d%0d_strobe_cycle", k), cyc, e.cyc);
        check($sformatf("d%0d_move_pulse", k), int'(mv), int'(e.mv));
        check($sformatf("d%0d_select_pulse", k), int'(sp), int'(e.sp));
        check($sformatf("d%0d_cursor_x", k), int'(cx), e.x);
        check($sformatf("d%0d_cursor_y", k), int'(cy), e.y);
        check($sformatf("d%0d_sel_x", k), int'(sx), e.sx);
        check($sformatf("d%0d_sel_y", k), int'(sy), e.sy);
      end
    end else if (qsize(k) != 0) begin
      e = qfront(k);
      if (e.cyc < cyc) begin
        e = qpop(k);
        check($sformatf("d%0d_missed_strobe_due_%0d", k, e.cyc), 0, 1);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, bus0.move_pulse, bus0.select_pulse, bus0.cursor_x, bus0.cursor_y, bus0.sel_x, bus0.sel_y);
    mon(1, bus1.move_pulse, bus1.select_pulse, bus1.cursor_x, bus1.cursor_y, bus1.sel_x, bus1.sel_y);
    mon(2, bus2.move_pulse, bus2.select_pulse, bus2.cursor_x, bus2.cursor_y, bus2.sel_x, bus2.sel_y);
  end

  task automatic check_zero(input string tag);
    check({tag, "_cursor_x"}, int'(bus0.cursor_x), 0);
    check({tag, "_cursor_y"}, int'(bus0.cursor_y), 0);
    check({tag, "_sel_x"}, int'(bus0.sel_x), 0);
    check({tag, "_sel_y"}, int'(bus0.sel_y), 0);
    check({tag, "_move_pulse"}, int'(bus0.move_pulse), 0);
    check({tag, "_select_pulse"}, int'(bus0.select_pulse), 0);
    check({tag, "_d2_cursor_x"}, int'(bus2.cursor_x), 0);
  endtask

  initial begin
    int n;
    drive(5'b0);
    model_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Long steady hold: one move at LAT, nothing on release.
    press(M_RIGHT, 20);

    // Glitches shorter than the debounce window: no strobe anywhere.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(M_RIGHT);
      repeat (3) @(negedge clk);
      drive(5'b0);
      repeat (2) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    check("glitch_d0_cursor_x", int'(bus0.cursor_x), int'(mx[0]));
    check("glitch_d0_cursor_y", int'(bus0.cursor_y), int'(my[0]));

    // Nine more rights: 8x8 wraps 7->0, 5x5 wraps 4->0, 5x5 saturates at 4.
    for (int i = 0; i < 9; i++) press(M_RIGHT, 8);

    // Up and down cancel, right still applies.
    press(M_UDR, 8);

    // Reset in the middle of debouncing a held up button.
    @(negedge clk);
    drive(M_UP);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    check_zero("midreset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    n = cyc;
    model_press(M_UP, n, 10);
    repeat (10) @(negedge clk);
    drive(5'b0);
    repeat (10) @(negedge clk);

    // Left at x=0: wraps on the wrapping boards, silent on the saturating one.
    press(M_LEFT, 8);

    // Walk the 8x8 board to (2,3), then select together with a right press.
    for (int i = 0; i < 3; i++) press(M_RIGHT, 8);
    for (int i = 0; i < 2; i++) press(M_UP, 8);
    press(M_SELR, 8);

`ifdef CHESS_CURSOR_AUTOREPEAT_EN
    // Held up: first move, then repeats at +10, +13, +16.
    press(M_UP, 18);
`endif

    repeat (5) @(negedge clk);
    for (int k = 0; k < 3; k++) check($sformatf("d%0d_pending_strobes", k), qsize(k), 0);
    check("final_d0_cursor_x", int'(bus0.cursor_x), int'(mx[0]));
    check("final_d0_cursor_y", int'(bus0.cursor_y), int'(my[0]));
    check("final_d1_cursor_x", int'(bus1.cursor_x), int'(mx[1]));
    check("final_d2_cursor_x", int'(bus2.cursor_x), int'(mx[2]));
    check("final_d0_sel_x", int'(bus0.sel_x), int'(msx[0]));
    check("final_d0_sel_y", int'(bus0.sel_y), int'(msy[0]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
